vector_lane_mov_unit: RTL and testbench

- Parametrised, registered successor to the single-cycle 4-lane scalar-to-vector insert.
- Lane count and lane width are generic.
- Supports four operations: INSERT, EXTRACT, BROADCAST and a multi-beat PACK, which assembles a vector from a stream of scalars.
- Sits between the scalar register file / ALU and the vector register file, with valid/ready handshake on input and output.

---
 rtl/vector_lane_mov_unit.sv | 148 ++++++++++++++
 tb/tb_vector_lane_mov_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_mov_unit.sv
// Registered lane move unit: INSERT, EXTRACT, BROADCAST and multi-beat PACK between the
// scalar and vector register files, with a single-entry output register and valid/ready.
module vector_lane_mov_unit #(
   parameter int N  = 32,
   parameter int L  = 4,
   parameter int LW = $clog2(L),
   parameter int V  = N * L
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic [LW-1:0] lane,
   input  logic [N-1:0]  src,
   input  logic [V-1:0]  vector_input,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [V-1:0]  dst,
   output logic [N-1:0]  scalar_out,
   output logic          lane_err
);

   localparam logic [1:0]    OP_INSERT    = 2'd0;
   localparam logic [1:0]    OP_EXTRACT   = 2'd1;
   localparam logic [1:0]    OP_BROADCAST = 2'd2;
   localparam logic [1:0]    OP_PACK      = 2'd3;
   localparam logic [LW-1:0] LAST_LANE    = LW'(L - 1);

   typedef enum logic {IDLE, PACK} state_t;

   state_t        state, next_state;
   logic [V-1:0]  pack_buf, pack_buf_n;
   logic [LW-1:0] cnt, cnt_n, next_idx;
   logic          slot_free, accept, lane_bad, load;
   logic [V-1:0]  res_dst, lane_put;
   logic [N-1:0]  res_scalar, lane_get;
   logic          res_err;

   function automatic logic [V-1:0] put_lane(input logic [V-1:0] vec, input logic [LW-1:0] idx,
                                             input logic [N-1:0] val);
      logic [V-1:0] r;
      r = vec;
      for (int k = 0; k < L; k++)
         if (idx == LW'(k)) r[k*N +: N] = val;
      return r;
   endfunction

   function automatic logic [N-1:0] get_lane(input logic [V-1:0] vec, input logic [LW-1:0] idx);
      logic [N-1:0] r;
      r = '0;
      for (int k = 0; k < L; k++)
         if (idx == LW'(k)) r = vec[k*N +: N];
      return r;
   endfunction

   assign slot_free = !out_valid | out_ready;
   assign in_ready  = slot_free;
   assign accept    = in_valid & in_ready;
   assign lane_bad  = ({1'b0, lane} >= (LW+1)'(L));
   assign lane_put  = put_lane(vector_input, lane, src);
   assign lane_get  = get_lane(vector_input, lane);
   assign next_idx  = cnt + LW'(1);

   // Decode the accepted beat into either a result for the output register or a PACK step.
   always_comb begin
      next_state = state;
      pack_buf_n = pack_buf;
      cnt_n      = cnt;
      load       = 1'b0;
      res_dst    = vector_input;
      res_scalar = '0;
      res_err    = 1'b0;
      if (accept) begin
         if (state == IDLE) begin
            if (op != OP_BROADCAST && lane_bad) begin
               load    = 1'b1;
               res_err = 1'b1;
            end else begin
               case (op)
                  OP_INSERT: begin
                     load       = 1'b1;
                     res_dst    = lane_put;
                     res_scalar = lane_get;
                  end
                  OP_EXTRACT: begin
                     load       = 1'b1;
                     res_scalar = lane_get;
                  end
                  OP_BROADCAST: begin
                     load       = 1'b1;
                     res_dst    = {L{src}};
                     res_scalar = src;
                  end
                  OP_PACK: begin
                     pack_buf_n = lane_put;
                     cnt_n      = lane;
                     if (lane == LAST_LANE) begin
                        load       = 1'b1;
                        res_dst    = lane_put;
                        res_scalar = src;
                     end else begin
                        next_state = PACK;
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            // Continuation beats fill upward from the start lane; lanes below it are never touched.
            pack_buf_n = put_lane(pack_buf, next_idx, src);
            cnt_n      = next_idx;
            if (next_idx == LAST_LANE) begin
               load       = 1'b1;
               res_dst    = pack_buf_n;
               res_scalar = src;
               next_state = IDLE;
            end
         end
      end
   end

   // State, pack buffer and the single-entry output register; a new load wins over a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pack_buf   <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         dst        <= '0;
         scalar_out <= '0;
         lane_err   <= 1'b0;
      end else begin
         state    <= next_state;
         pack_buf <= pack_buf_n;
         cnt      <= cnt_n;
         if (load) begin
            out_valid  <= 1'b1;
            dst        <= res_dst;
            scalar_out <= res_scalar;
            lane_err   <= res_err;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vector_lane_mov_unit.sv
// Directed self-checking bench for vector_lane_mov_unit: a 4-lane instance for the main
// operations and a 3-lane instance for out-of-range lane handling.
module tb_vector_lane_mov_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, lane_err;
   logic [1:0]   op;
   logic [1:0]   lane;
   logic [31:0]  src, scalar_out;
   logic [127:0] vector_input, dst;

   logic         t3_in_valid, t3_in_ready, t3_out_valid, t3_out_ready, t3_lane_err;
   logic [1:0]   t3_op, t3_lane;
   logic [31:0]  t3_src, t3_scalar_out;
   logic [95:0]  t3_vector_input, t3_dst;

   int checks = 0;
   int failures = 0;

   localparam logic [127:0] V0 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [95:0]  V3 = 96'h33333333_22222222_11111111;

   always #5 clk = ~clk;

   vector_lane_mov_unit #(.N(32), .L(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .lane(lane),
      .src(src), .vector_input(vector_input), .out_valid(out_valid), .out_ready(out_ready),
      .dst(dst), .scalar_out(scalar_out), .lane_err(lane_err)
   );

   vector_lane_mov_unit #(.N(32), .L(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(t3_in_valid), .in_ready(t3_in_ready), .op(t3_op),
      .lane(t3_lane), .src(t3_src), .vector_input(t3_vector_input), .out_valid(t3_out_valid),
      .out_ready(t3_out_ready), .dst(t3_dst), .scalar_out(t3_scalar_out), .lane_err(t3_lane_err)
   );

   // Present one beat for a single edge, then withdraw it; callers sample #1 after that edge.
   task automatic send(input logic [1:0] o, input logic [1:0] ln, input logic [31:0] s,
                       input logic [127:0] v);
      in_valid = 1'b1; op = o; lane = ln; src = s; vector_input = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send3(input logic [1:0] o, input logic [1:0] ln, input logic [31:0] s,
                        input logic [95:0] v);
      t3_in_valid = 1'b1; t3_op = o; t3_lane = ln; t3_src = s; t3_vector_input = v;
      @(posedge clk); #1;
      t3_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || dst !== 128'd0 || scalar_out !== 32'd0 || lane_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_values: out_valid=%b dst=%h scalar=%h err=%b, need 0/0/0/0",
                  out_valid, dst, scalar_out, lane_err);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_in_ready: got %b need 1", in_ready);
      end
      send(2'd2, 2'd0, 32'h5A5A5A5A, V0);
      send(2'd3, 2'd0, 32'h000000B1, V0);
      send(2'd3, 2'd0, 32'h000000B2, V0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || dst !== 128'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_pack: out_valid=%b dst=%h, need 0 and 0", out_valid, dst);
      end
      send(2'd3, 2'd2, 32'h000000C1, V0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL pack_restart_first: out_valid=%b need 0", out_valid);
      end
      send(2'd3, 2'd0, 32'h000000C2, 128'd0);
      checks++;
      if (out_valid !== 1'b1 || dst !== 128'h000000C2_000000C1_22222222_11111111 ||
          scalar_out !== 32'h000000C2) begin
         failures++;
         $display("[TB] FAIL pack_restart_result: out_valid=%b dst=%h scalar=%h, need 1 %h %h",
                  out_valid, dst, scalar_out, 128'h000000C2_000000C1_22222222_11111111, 32'hC2);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_insert_extract();
      send(2'd0, 2'd2, 32'hDEADBEEF, V0);
      checks++;
      if (out_valid !== 1'b1 || dst !== 128'h44444444_DEADBEEF_22222222_11111111 ||
          scalar_out !== 32'h33333333 || lane_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL insert: valid=%b dst=%h scalar=%h err=%b, need 1 %h 33333333 0",
                  out_valid, dst, scalar_out, lane_err, 128'h44444444_DEADBEEF_22222222_11111111);
      end
      send(2'd1, 2'd3, 32'h0, V0);
      checks++;
      if (out_valid !== 1'b1 || scalar_out !== 32'h44444444 || dst !== V0) begin
         failures++;
         $display("[TB] FAIL extract: valid=%b scalar=%h dst=%h, need 1 44444444 %h",
                  out_valid, scalar_out, dst, V0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; op = 2'd2; lane = 2'd1; src = 32'hA5A5A5A5; vector_input = V0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || dst !== {4{32'hA5A5A5A5}} || scalar_out !== 32'hA5A5A5A5 ||
          lane_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL broadcast: valid=%b dst=%h scalar=%h err=%b, need 1 %h a5a5a5a5 0",
                  out_valid, dst, scalar_out, lane_err, {4{32'hA5A5A5A5}});
      end
      op = 2'd0; lane = 2'd0; src = 32'h00000077;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_ready: in_ready=%b need 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || dst !== 128'h44444444_33333333_22222222_00000077 ||
          scalar_out !== 32'h11111111) begin
         failures++;
         $display("[TB] FAIL b2b_insert: valid=%b dst=%h scalar=%h, need 1 %h 11111111",
                  out_valid, dst, scalar_out, 128'h44444444_33333333_22222222_00000077);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_drain: out_valid=%b need 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(2'd1, 2'd1, 32'h0, V0);
      in_valid = 1'b1; op = 2'd2; lane = 2'd0; src = 32'h12345678; vector_input = V0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_in_ready: got %b need 0", in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || dst !== V0 || scalar_out !== 32'h22222222) begin
         failures++;
         $display("[TB] FAIL bp_hold: valid=%b dst=%h scalar=%h, need 1 %h 22222222",
                  out_valid, dst, scalar_out, V0);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release_ready: got %b need 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || dst !== {4{32'h12345678}} || scalar_out !== 32'h12345678) begin
         failures++;
         $display("[TB] FAIL bp_release_result: valid=%b dst=%h scalar=%h, need 1 %h 12345678",
                  out_valid, dst, scalar_out, {4{32'h12345678}});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_pack();
      logic gap_valid;
      out_ready = 1'b1;
      send(2'd3, 2'd1, 32'h000000B1, V0);
      gap_valid = out_valid;
      repeat (2) begin
         @(posedge clk); #1;
         gap_valid = gap_valid | out_valid;
      end
      send(2'd1, 2'd0, 32'h000000B2, 128'd0);
      gap_valid = gap_valid | out_valid;
      checks++;
      if (gap_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL pack_no_early_result: out_valid seen=%b need 0", gap_valid);
      end
      send(2'd0, 2'd3, 32'h000000B3, 128'd0);
      checks++;
      if (out_valid !== 1'b1 || dst !== 128'h000000B3_000000B2_000000B1_11111111 ||
          scalar_out !== 32'h000000B3 || lane_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL pack_result: valid=%b dst=%h scalar=%h err=%b, need 1 %h b3 0",
                  out_valid, dst, scalar_out, lane_err, 128'h000000B3_000000B2_000000B1_11111111);
      end
      send(2'd3, 2'd3, 32'h000000EE, V0);
      checks++;
      if (out_valid !== 1'b1 || dst !== 128'h000000EE_33333333_22222222_11111111 ||
          scalar_out !== 32'h000000EE) begin
         failures++;
         $display("[TB] FAIL pack_single_beat: valid=%b dst=%h scalar=%h, need 1 %h ee",
                  out_valid, dst, scalar_out, 128'h000000EE_33333333_22222222_11111111);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lane_range();
      t3_out_ready = 1'b1;
      send3(2'd0, 2'd3, 32'hDEADBEEF, V3);
      checks++;
      if (t3_out_valid !== 1'b1 || t3_lane_err !== 1'b1 || t3_dst !== V3 || t3_scalar_out !== 32'd0) begin
         failures++;
         $display("[TB] FAIL l3_insert_err: valid=%b err=%b dst=%h scalar=%h, need 1 1 %h 0",
                  t3_out_valid, t3_lane_err, t3_dst, t3_scalar_out, V3);
      end
      send3(2'd3, 2'd3, 32'h000000AB, V3);
      checks++;
      if (t3_out_valid !== 1'b1 || t3_lane_err !== 1'b1 || t3_dst !== V3 || t3_scalar_out !== 32'd0) begin
         failures++;
         $display("[TB] FAIL l3_pack_err: valid=%b err=%b dst=%h scalar=%h, need 1 1 %h 0",
                  t3_out_valid, t3_lane_err, t3_dst, t3_scalar_out, V3);
      end
      send3(2'd1, 2'd1, 32'h0, V3);
      checks++;
      if (t3_out_valid !== 1'b1 || t3_lane_err !== 1'b0 || t3_scalar_out !== 32'h22222222 ||
          t3_dst !== V3) begin
         failures++;
         $display("[TB] FAIL l3_idle_after_err: valid=%b err=%b scalar=%h dst=%h, need 1 0 22222222 %h",
                  t3_out_valid, t3_lane_err, t3_scalar_out, t3_dst, V3);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; op = 2'd0; lane = 2'd0; src = '0; vector_input = '0; out_ready = 1'b1;
      t3_in_valid = 1'b0; t3_op = 2'd0; t3_lane = 2'd0; t3_src = '0; t3_vector_input = '0;
      t3_out_ready = 1'b1;
      #1;
      test_reset();
      test_insert_extract();
      test_back_to_back();
      test_backpressure();
      test_pack();
      test_lane_range();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
